// File: rtl/alu_dispatch_stage_pkg.sv
// Shared encodings for the ALU dispatch stage: default bus widths, the
// free/NOP encodings, the ALU tag prefix and the hold-buffer state type.
package alu_dispatch_stage_pkg;

  localparam int unsigned RS_SIZE_DEF = 8;
  localparam int unsigned TAG_W_DEF   = 6;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned NAME_W_DEF  = 5;
  localparam int unsigned OP_W        = 5;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned ROOT_W_DEF  = $clog2(RS_SIZE_DEF);

  // Upper tag bits identifying the ALU reservation station; low bits are the entry index.
  localparam logic [TAG_W_DEF-ROOT_W_DEF-1:0] ALU_TAG_PREFIX = 3'b001;

  localparam logic [TAG_W_DEF-1:0]  TAG_FREE  = '0;
  localparam logic [DATA_W_DEF-1:0] DATA_FREE = '0;
  localparam logic [NAME_W_DEF-1:0] NAME_FREE = '0;
  localparam logic [ADDR_W-1:0]     ADDR_FREE = '0;
  localparam logic [OP_W-1:0]       OP_NOP    = '0;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/alu_dispatch_stage_if.sv
// Decode-side input, result broadcasts, RS allocation bus and rename write
// of the ALU dispatch stage. master = dispatch stage, slave = environment.
interface alu_dispatch_stage_if
  import alu_dispatch_stage_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NAME_W  = NAME_W_DEF
);
  logic               flush;
  logic               inValid;
  logic               inReady;
  logic [OP_W-1:0]    inOp;
  logic [ADDR_W-1:0]  inAddr;
  logic [DATA_W-1:0]  inDataO;
  logic [TAG_W-1:0]   inTagO;
  logic [DATA_W-1:0]  inDataT;
  logic [TAG_W-1:0]   inTagT;
  logic [NAME_W-1:0]  inNameW;

  logic               enALUwrt;
  logic [TAG_W-1:0]   ALUtag;
  logic [DATA_W-1:0]  ALUdata;
  logic               enLSwrt;
  logic [TAG_W-1:0]   LStag;
  logic [DATA_W-1:0]  LSdata;

  logic [RS_SIZE-1:0] ALUfreeStatus;
  logic               ALUen;
  logic [DATA_W-1:0]  ALUoperandO;
  logic [DATA_W-1:0]  ALUoperandT;
  logic [TAG_W-1:0]   ALUtagO;
  logic [TAG_W-1:0]   ALUtagT;
  logic [TAG_W-1:0]   ALUtagW;
  logic [NAME_W-1:0]  ALUnameW;
  logic [OP_W-1:0]    ALUop;
  logic [ADDR_W-1:0]  ALUaddr;

  logic               rnEn;
  logic [NAME_W-1:0]  rnName;
  logic [TAG_W-1:0]   rnTag;

  modport master (
    input  flush, inValid, inOp, inAddr, inDataO, inTagO, inDataT, inTagT, inNameW,
    input  enALUwrt, ALUtag, ALUdata, enLSwrt, LStag, LSdata, ALUfreeStatus,
    output inReady, ALUen, ALUoperandO, ALUoperandT, ALUtagO, ALUtagT, ALUtagW,
    output ALUnameW, ALUop, ALUaddr, rnEn, rnName, rnTag
  );

  modport slave (
    output flush, inValid, inOp, inAddr, inDataO, inTagO, inDataT, inTagT, inNameW,
    output enALUwrt, ALUtag, ALUdata, enLSwrt, LStag, LSdata, ALUfreeStatus,
    input  inReady, ALUen, ALUoperandO, ALUoperandT, ALUtagO, ALUtagT, ALUtagW,
    input  ALUnameW, ALUop, ALUaddr, rnEn, rnName, rnTag
  );
endinterface

// File: rtl/alu_dispatch_stage_cdb_fwd.sv
// Per-operand forwarding mux: replaces a pending operand with a matching
// ALU or LS result broadcast (ALU wins). A free tag is never matched.
module alu_dispatch_stage_cdb_fwd
  import alu_dispatch_stage_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              alu_en_i,
  input  logic [TAG_W-1:0]  alu_tag_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              ls_en_i,
  input  logic [TAG_W-1:0]  ls_tag_i,
  input  logic [DATA_W-1:0] ls_data_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);
  localparam logic [TAG_W-1:0] TagFreeP = TAG_W'(TAG_FREE);

  // Two-source tag match, ALU broadcast taking priority over LS.
  always_comb begin
    tag_o  = tag_i;
    data_o = data_i;
    if (tag_i != TagFreeP) begin
      if (alu_en_i && (alu_tag_i == tag_i)) begin
        tag_o  = TagFreeP;
        data_o = alu_data_i;
      end else if (ls_en_i && (ls_tag_i == tag_i)) begin
        tag_o  = TagFreeP;
        data_o = ls_data_i;
      end
    end
  end
endmodule

// File: rtl/alu_dispatch_stage.sv
// ALU dispatch stage: single-entry hold buffer between decode and the ALU
// reservation station. Allocates the lowest free RS entry, drives the rename
// write, and folds result broadcasts into operands every cycle.
// Optional build macro: ALU_DISPATCH_PERF_EN (stall/dispatch counters).
module alu_dispatch_stage
  import alu_dispatch_stage_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NAME_W  = NAME_W_DEF
) (
  input logic clk,
  input logic rst,
  alu_dispatch_stage_if.master bus
`ifdef ALU_DISPATCH_PERF_EN
  ,
  output logic [31:0] stallFullCnt,
  output logic [31:0] dispCnt
`endif
);
  localparam int unsigned ROOT_W   = $clog2(RS_SIZE);
  localparam int unsigned PREFIX_W = TAG_W - ROOT_W;
  localparam logic [PREFIX_W-1:0] PrefixP    = PREFIX_W'(ALU_TAG_PREFIX);
  localparam logic [TAG_W-1:0]    TagFreeP   = TAG_W'(TAG_FREE);
  localparam logic [DATA_W-1:0]   DataFreeP  = DATA_W'(DATA_FREE);
  localparam logic [NAME_W-1:0]   NameFreeP  = NAME_W'(NAME_FREE);

  // Isolate the lowest set bit (x & -x) and encode its position.
  function automatic logic [ROOT_W-1:0] lowest_free(input logic [RS_SIZE-1:0] v);
    logic [RS_SIZE-1:0] onehot;
    logic [ROOT_W-1:0]  idx;
    onehot = v & (-v);
    idx    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (onehot[i]) idx = ROOT_W'(i);
    end
    return idx;
  endfunction

  hold_state_e       state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dataO_q, dataO_d, dataT_q, dataT_d;
  logic [TAG_W-1:0]  tagO_q, tagO_d, tagT_q, tagT_d;
  logic [NAME_W-1:0] nameW_q, nameW_d;

  logic [DATA_W-1:0] hDataO, hDataT, iDataO, iDataT;
  logic [TAG_W-1:0]  hTagO, hTagT, iTagO, iTagT;

  logic              held, canAlloc, aluEn, inReady, load;
  logic [ROOT_W-1:0] sel;

  alu_dispatch_stage_cdb_fwd #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_fwd_held_o (
    .tag_i(tagO_q), .data_i(dataO_q),
    .alu_en_i(bus.enALUwrt), .alu_tag_i(bus.ALUtag), .alu_data_i(bus.ALUdata),
    .ls_en_i(bus.enLSwrt), .ls_tag_i(bus.LStag), .ls_data_i(bus.LSdata),
    .tag_o(hTagO), .data_o(hDataO)
  );

  alu_dispatch_stage_cdb_fwd #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_fwd_held_t (
    .tag_i(tagT_q), .data_i(dataT_q),
    .alu_en_i(bus.enALUwrt), .alu_tag_i(bus.ALUtag), .alu_data_i(bus.ALUdata),
    .ls_en_i(bus.enLSwrt), .ls_tag_i(bus.LStag), .ls_data_i(bus.LSdata),
    .tag_o(hTagT), .data_o(hDataT)
  );

  alu_dispatch_stage_cdb_fwd #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_fwd_in_o (
    .tag_i(bus.inTagO), .data_i(bus.inDataO),
    .alu_en_i(bus.enALUwrt), .alu_tag_i(bus.ALUtag), .alu_data_i(bus.ALUdata),
    .ls_en_i(bus.enLSwrt), .ls_tag_i(bus.LStag), .ls_data_i(bus.LSdata),
    .tag_o(iTagO), .data_o(iDataO)
  );

  alu_dispatch_stage_cdb_fwd #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_fwd_in_t (
    .tag_i(bus.inTagT), .data_i(bus.inDataT),
    .alu_en_i(bus.enALUwrt), .alu_tag_i(bus.ALUtag), .alu_data_i(bus.ALUdata),
    .ls_en_i(bus.enLSwrt), .ls_tag_i(bus.LStag), .ls_data_i(bus.LSdata),
    .tag_o(iTagT), .data_o(iDataT)
  );

  // Allocation and handshake decisions for this cycle.
  always_comb begin
    held     = (state_q == HOLD_FULL);
    canAlloc = |bus.ALUfreeStatus;
    sel      = lowest_free(bus.ALUfreeStatus);
    aluEn    = held & canAlloc & ~bus.flush;
    inReady  = ~bus.flush & (~held | aluEn);
    load     = bus.inValid & inReady;
  end

  // Next hold-buffer contents: flush drops, load replaces (even while
  // allocating), otherwise the held operands absorb matching broadcasts.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    nameW_d = nameW_q;
    dataO_d = hDataO;
    tagO_d  = hTagO;
    dataT_d = hDataT;
    tagT_d  = hTagT;
    if (bus.flush) begin
      state_d = HOLD_EMPTY;
    end else if (load) begin
      state_d = HOLD_FULL;
      op_d    = bus.inOp;
      addr_d  = bus.inAddr;
      nameW_d = bus.inNameW;
      dataO_d = iDataO;
      tagO_d  = iTagO;
      dataT_d = iDataT;
      tagT_d  = iTagT;
    end else if (aluEn) begin
      state_d = HOLD_EMPTY;
    end
  end

  // Hold-buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD_EMPTY;
      op_q    <= OP_NOP;
      addr_q  <= ADDR_FREE;
      nameW_q <= NameFreeP;
      dataO_q <= DataFreeP;
      tagO_q  <= TagFreeP;
      dataT_q <= DataFreeP;
      tagT_q  <= TagFreeP;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      nameW_q <= nameW_d;
      dataO_q <= dataO_d;
      tagO_q  <= tagO_d;
      dataT_q <= dataT_d;
      tagT_q  <= tagT_d;
    end
  end

  // Allocation bus and rename write; free values whenever not allocating.
  always_comb begin
    bus.inReady     = inReady;
    bus.ALUen       = aluEn;
    bus.ALUoperandO = DataFreeP;
    bus.ALUoperandT = DataFreeP;
    bus.ALUtagO     = TagFreeP;
    bus.ALUtagT     = TagFreeP;
    bus.ALUtagW     = TagFreeP;
    bus.ALUnameW    = NameFreeP;
    bus.ALUop       = OP_NOP;
    bus.ALUaddr     = ADDR_FREE;
    if (aluEn) begin
      bus.ALUoperandO = hDataO;
      bus.ALUoperandT = hDataT;
      bus.ALUtagO     = hTagO;
      bus.ALUtagT     = hTagT;
      bus.ALUtagW     = {PrefixP, sel};
      bus.ALUnameW    = nameW_q;
      bus.ALUop       = op_q;
      bus.ALUaddr     = addr_q;
    end
    bus.rnEn   = aluEn;
    bus.rnName = bus.ALUnameW;
    bus.rnTag  = bus.ALUtagW;
  end

`ifdef ALU_DISPATCH_PERF_EN
  // Saturating counters for full-RS stall cycles and dispatched instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallFullCnt <= '0;
      dispCnt      <= '0;
    end else begin
      if (held && !canAlloc && (stallFullCnt != '1)) stallFullCnt <= stallFullCnt + 32'd1;
      if (aluEn && (dispCnt != '1)) dispCnt <= dispCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_dispatch_stage.sv
// Self-checking bench for alu_dispatch_stage: table of single-instruction
// vectors plus hand sequences for stall, forwarding races, flush and streaming.
module tb_alu_dispatch_stage;
  import alu_dispatch_stage_pkg::*;

  localparam int unsigned RS = 8;
  localparam int unsigned TW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_dispatch_stage_if #(.RS_SIZE(RS), .TAG_W(TW), .DATA_W(DW), .NAME_W(NW)) bus ();

  alu_dispatch_stage #(.RS_SIZE(RS), .TAG_W(TW), .DATA_W(DW), .NAME_W(NW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     dO;
    logic [TW-1:0]     tO;
    logic [DW-1:0]     dT;
    logic [TW-1:0]     tT;
    logic [NW-1:0]     name;
    logic [TW-1:0]     tagW;
  } exp_t;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     dO;
    logic [TW-1:0]     tO;
    logic [DW-1:0]     dT;
    logic [TW-1:0]     tT;
    logic [NW-1:0]     name;
    logic [RS-1:0]     free;
    int                sel;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // ALU RS tags are prefix 3'b001 over a 3-bit entry index.
  function automatic logic [TW-1:0] alu_tag(input int sel);
    logic [2:0] idx;
    idx = 3'(sel);
    return {3'b001, idx};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inValid  = 1'b0;
    bus.flush    = 1'b0;
    bus.enALUwrt = 1'b0;
    bus.enLSwrt  = 1'b0;
  endtask

  task automatic set_instr(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [DW-1:0] dO, input logic [TW-1:0] tO,
                           input logic [DW-1:0] dT, input logic [TW-1:0] tT,
                           input logic [NW-1:0] name);
    bus.inValid = 1'b1;
    bus.inOp    = op;
    bus.inAddr  = addr;
    bus.inDataO = dO;
    bus.inTagO  = tO;
    bus.inDataT = dT;
    bus.inTagT  = tT;
    bus.inNameW = name;
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                      input logic [DW-1:0] dO, input logic [TW-1:0] tO,
                      input logic [DW-1:0] dT, input logic [TW-1:0] tT,
                      input logic [NW-1:0] name, input logic [TW-1:0] tagW);
    exp_t e;
    e.op = op; e.addr = addr; e.dO = dO; e.tO = tO; e.dT = dT; e.tT = tT;
    e.name = name; e.tagW = tagW;
    sbq.push_back(e);
  endtask

  // Scoreboard: every allocation must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.ALUen === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_alloc: ALUen=1 tagW=0x%0h op=0x%0h, required no allocation (t=%0t)",
                 bus.ALUtagW, bus.ALUop, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("alloc_op", 64'(bus.ALUop), 64'(mon_e.op));
        chk("alloc_addr", 64'(bus.ALUaddr), 64'(mon_e.addr));
        chk("alloc_operandO", 64'(bus.ALUoperandO), 64'(mon_e.dO));
        chk("alloc_tagO", 64'(bus.ALUtagO), 64'(mon_e.tO));
        chk("alloc_operandT", 64'(bus.ALUoperandT), 64'(mon_e.dT));
        chk("alloc_tagT", 64'(bus.ALUtagT), 64'(mon_e.tT));
        chk("alloc_nameW", 64'(bus.ALUnameW), 64'(mon_e.name));
        chk("alloc_tagW", 64'(bus.ALUtagW), 64'(mon_e.tagW));
        chk("rnEn", 64'(bus.rnEn), 64'd1);
        chk("rnName", 64'(bus.rnName), 64'(mon_e.name));
        chk("rnTag", 64'(bus.rnTag), 64'(mon_e.tagW));
      end
    end
  end

  vec_t vecs[4];

  initial begin
    vecs[0] = '{op: 5'h03, addr: 32'h1000, dO: 32'h11, tO: 6'd0, dT: 32'h22, tT: 6'd0,
                name: 5'd1, free: 8'b0000_0100, sel: 2};
    vecs[1] = '{op: 5'h07, addr: 32'h1004, dO: 32'hA5A5, tO: 6'd0, dT: 32'h5A5A, tT: 6'd0,
                name: 5'd31, free: 8'b1000_0000, sel: 7};
    vecs[2] = '{op: 5'h1F, addr: 32'hFFFF_FFFC, dO: 32'hFFFF_FFFF, tO: 6'd0, dT: 32'h0, tT: 6'd0,
                name: 5'd0, free: 8'b1111_1111, sel: 0};
    vecs[3] = '{op: 5'h0A, addr: 32'h2000, dO: 32'h1, tO: 6'd6, dT: 32'h2, tT: 6'd20,
                name: 5'd9, free: 8'b0110_0000, sel: 5};

    rst = 1'b1;
    idle();
    bus.inOp = '0; bus.inAddr = '0; bus.inDataO = '0; bus.inTagO = '0;
    bus.inDataT = '0; bus.inTagT = '0; bus.inNameW = '0;
    bus.ALUtag = '0; bus.ALUdata = '0; bus.LStag = '0; bus.LSdata = '0;
    bus.ALUfreeStatus = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_ALUen", 64'(bus.ALUen), 64'd0);
    chk("rst_rnEn", 64'(bus.rnEn), 64'd0);
    chk("rst_inReady", 64'(bus.inReady), 64'd1);
    chk("rst_tagW", 64'(bus.ALUtagW), 64'(TAG_FREE));
    chk("rst_operandO", 64'(bus.ALUoperandO), 64'd0);
    chk("rst_op", 64'(bus.ALUop), 64'(OP_NOP));
    step();
    rst = 1'b0;

    // Table: load one instruction, allocate it next cycle, then nothing.
    for (int i = 0; i < 4; i++) begin
      step();
      set_instr(vecs[i].op, vecs[i].addr, vecs[i].dO, vecs[i].tO, vecs[i].dT, vecs[i].tT,
                vecs[i].name);
      bus.ALUfreeStatus = vecs[i].free;
      push(vecs[i].op, vecs[i].addr, vecs[i].dO, vecs[i].tO, vecs[i].dT, vecs[i].tT,
           vecs[i].name, alu_tag(vecs[i].sel));
      @(negedge clk);
      chk("tbl_inReady_load", 64'(bus.inReady), 64'd1);
      chk("tbl_ALUen_load", 64'(bus.ALUen), 64'd0);
      step();
      idle();
      @(negedge clk);
      chk("tbl_ALUen_alloc", 64'(bus.ALUen), 64'd1);
      chk("tbl_inReady_alloc", 64'(bus.inReady), 64'd1);
      step();
      @(negedge clk);
      chk("tbl_ALUen_after", 64'(bus.ALUen), 64'd0);
    end

    // Full RS stall with LS broadcast resolving held operand O; decoy input must be refused.
    step();
    set_instr(5'h02, 32'h3000, 32'h1111, 6'd5, 32'h22, 6'd0, 5'd7);
    bus.ALUfreeStatus = '0;
    push(5'h02, 32'h3000, 32'hDEAD, 6'd0, 32'h22, 6'd0, 5'd7, alu_tag(0));
    @(negedge clk);
    chk("stall_load_inReady", 64'(bus.inReady), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      idle();
      set_instr(5'h15, 32'hBAD0, 32'hBAD1, 6'd0, 32'hBAD2, 6'd0, 5'd30);
      if (i == 2) begin
        bus.enLSwrt = 1'b1;
        bus.LStag   = 6'd5;
        bus.LSdata  = 32'hDEAD;
      end
      @(negedge clk);
      chk("stall_ALUen", 64'(bus.ALUen), 64'd0);
      chk("stall_inReady", 64'(bus.inReady), 64'd0);
    end
    step();
    idle();
    bus.ALUfreeStatus = 8'b0000_0001;
    @(negedge clk);
    chk("stall_release_ALUen", 64'(bus.ALUen), 64'd1);
    step();
    bus.ALUfreeStatus = 8'hFF;
    @(negedge clk);
    chk("stall_no_dup", 64'(bus.ALUen), 64'd0);

    // ALU broadcast in the allocation cycle must be folded into operand T.
    step();
    set_instr(5'h04, 32'h4000, 32'h10, 6'd0, 32'h55, 6'd3, 5'd12);
    bus.ALUfreeStatus = '0;
    push(5'h04, 32'h4000, 32'h10, 6'd0, 32'h7, 6'd0, 5'd12, alu_tag(1));
    step();
    idle();
    @(negedge clk);
    chk("race_hold_ALUen", 64'(bus.ALUen), 64'd0);
    step();
    bus.ALUfreeStatus = 8'b0000_0010;
    bus.enALUwrt = 1'b1;
    bus.ALUtag   = 6'd3;
    bus.ALUdata  = 32'h7;
    @(negedge clk);
    chk("race_ALUen", 64'(bus.ALUen), 64'd1);
    step();
    idle();
    bus.ALUfreeStatus = '0;

    // Simultaneous ALU and LS broadcast to held tag 4: ALU value must win.
    step();
    set_instr(5'h06, 32'h5000, 32'h99, 6'd4, 32'h44, 6'd0, 5'd3);
    push(5'h06, 32'h5000, 32'h1, 6'd0, 32'h44, 6'd0, 5'd3, alu_tag(3));
    step();
    idle();
    bus.enALUwrt = 1'b1; bus.ALUtag = 6'd4; bus.ALUdata = 32'h1;
    bus.enLSwrt  = 1'b1; bus.LStag  = 6'd4; bus.LSdata  = 32'h2;
    @(negedge clk);
    chk("prio_hold_ALUen", 64'(bus.ALUen), 64'd0);
    step();
    idle();
    bus.ALUfreeStatus = 8'b0000_1000;
    @(negedge clk);
    chk("prio_ALUen", 64'(bus.ALUen), 64'd1);
    step();
    bus.ALUfreeStatus = '0;

    // Incoming operand resolved by same-cycle broadcast; free-tag broadcast ignored.
    step();
    set_instr(5'h08, 32'h6000, 32'hBAD, 6'd10, 32'h33, 6'd0, 5'd4);
    bus.enALUwrt = 1'b1; bus.ALUtag = 6'd10; bus.ALUdata = 32'h77;
    bus.enLSwrt  = 1'b1; bus.LStag  = 6'd0;  bus.LSdata  = 32'h99;
    push(5'h08, 32'h6000, 32'h77, 6'd0, 32'h33, 6'd0, 5'd4, alu_tag(4));
    step();
    idle();
    bus.enLSwrt = 1'b1; bus.LStag = 6'd0; bus.LSdata = 32'h99;
    bus.ALUfreeStatus = 8'b0001_0000;
    @(negedge clk);
    chk("capture_ALUen", 64'(bus.ALUen), 64'd1);
    step();
    idle();
    bus.ALUfreeStatus = '0;

    // Flush with a free RS entry: no allocation now or later, decoy dropped.
    step();
    set_instr(5'h09, 32'h7000, 32'h1, 6'd0, 32'h2, 6'd0, 5'd5);
    step();
    set_instr(5'h1E, 32'h7004, 32'h3, 6'd0, 32'h4, 6'd0, 5'd6);
    bus.flush = 1'b1;
    bus.ALUfreeStatus = 8'hFF;
    @(negedge clk);
    chk("flush_ALUen", 64'(bus.ALUen), 64'd0);
    chk("flush_inReady", 64'(bus.inReady), 64'd0);
    chk("flush_rnEn", 64'(bus.rnEn), 64'd0);
    chk("flush_tagW", 64'(bus.ALUtagW), 64'(TAG_FREE));
    step();
    idle();
    @(negedge clk);
    chk("post_flush_ALUen", 64'(bus.ALUen), 64'd0);
    chk("post_flush_inReady", 64'(bus.inReady), 64'd1);
    step();
    @(negedge clk);
    chk("post_flush_ALUen2", 64'(bus.ALUen), 64'd0);

    // Reset while holding: entry dropped, nothing allocated afterwards.
    step();
    set_instr(5'h0B, 32'h9000, 32'h5, 6'd0, 32'h6, 6'd0, 5'd8);
    bus.ALUfreeStatus = '0;
    step();
    idle();
    rst = 1'b1;
    bus.ALUfreeStatus = 8'hFF;
    @(negedge clk);
    chk("rst_hold_ALUen", 64'(bus.ALUen), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_ALUen2", 64'(bus.ALUen), 64'd0);
    chk("rst_hold_inReady", 64'(bus.inReady), 64'd1);

    // Back-to-back stream of 4 with all entries free: 4 consecutive allocations.
    for (int i = 0; i < 4; i++) begin
      step();
      set_instr(5'(i + 1), 32'h8000 + 32'(4 * i), 32'(i), 6'd0, 32'(2 * i), 6'd0, 5'(16 + i));
      bus.ALUfreeStatus = 8'hFF;
      push(5'(i + 1), 32'h8000 + 32'(4 * i), 32'(i), 6'd0, 32'(2 * i), 6'd0, 5'(16 + i), alu_tag(0));
      @(negedge clk);
      chk("b2b_inReady", 64'(bus.inReady), 64'd1);
      chk("b2b_ALUen", 64'(bus.ALUen), (i > 0) ? 64'd1 : 64'd0);
    end
    step();
    idle();
    @(negedge clk);
    chk("b2b_ALUen_last", 64'(bus.ALUen), 64'd1);
    step();
    @(negedge clk);
    chk("b2b_ALUen_done", 64'(bus.ALUen), 64'd0);

    step();
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
